div_repeated_sub: RTL
=====================

Name: div_repeated_sub

Overview:
Sequential unsigned integer divider that computes quotient and remainder by repeated subtraction. It is the inverse companion of the team's repeated-addition multiplier. It uses the same operand-loading handshake: a start pulse, then dividend and divisor presented on a shared data_in bus on consecutive cycles, then a done flag. It is built as a controller FSM plus one datapath sub-module.

Parameters:
WIDTH, 16, operand/quotient/remainder width in bits (unsigned)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin operation; sampled in S_IDLE/S_DONE only
data_in  input  WIDTH  shared operand bus: dividend, then divisor on the next cycle
quotient  output  WIDTH  quotient register; valid while done=1
remainder  output  WIDTH  remainder register; valid while done=1
done  output  1  level; high in S_DONE until next start
busy  output  1  high in S_LDA, S_LDB, S_CHK, S_SUB
div_by_zero  output  1  high in S_DONE when divisor was 0; cleared on next start

Behaviour:
- Reset (async, rst_n=0): state=S_IDLE; quotient, remainder, divisor reg, done, busy, div_by_zero all 0. Reset asserted mid-operation aborts immediately with the same values; no partial result is retained.
- Edge numbering: E0 = clock edge at which start=1 is sampled.
- State S_IDLE: start=1 -> S_LDA.
- State S_LDA: remainder <= data_in (dividend) at E1 -> S_LDB.
- State S_LDB: divisor <= data_in and quotient <= 0 at E2 -> S_CHK.
- State S_CHK: if divisor==0 then div_by_zero <= 1, quotient <= all ones, remainder unchanged (= dividend), -> S_DONE at E3. Else -> S_SUB at E3.
- State S_SUB: each edge, if remainder >= divisor then remainder <= remainder - divisor and quotient <= quotient + 1, stay. Otherwise registers hold -> S_DONE.
- State S_DONE: done=1, outputs stable. start=1 -> S_LDA with done and div_by_zero cleared, so back-to-back operations skip S_IDLE. Otherwise stay.
- Latency: done rises after E(4+Q), where Q = final quotient. Divide-by-zero rises after E3. Worst case 65535/1 takes 65539 edges.
- Compare is unsigned WIDTH-bit (remainder >= divisor). Subtraction never underflows because it is guarded by the compare. Quotient never overflows because Q <= dividend.
- start while busy=1 is ignored and has no effect on state or registers.
- quotient/remainder are driven straight from registers and show in-progress values while busy. Consumers read them only while done=1.
- Dividend < divisor: zero subtractions; Q=0, R=dividend.
- Dividend == 0 with a nonzero divisor: Q=0, R=0.

Decomposition:
- Shared package/header: state encoding localparams (S_IDLE, S_LDA, S_LDB, S_CHK, S_SUB, S_DONE, 3-bit) and default WIDTH.
- Sub-module div_datapath holds the following:
  - remainder, divisor and quotient registers
  - subtractor, incrementer and >= comparator
  - zero detect on the divisor
- Control inputs to div_datapath: ldR, ldD, clrQ, sub_en, set_dbz.
- Status outputs from div_datapath: ge, dz.
- The FSM lives in div_repeated_sub and drives div_datapath.

Test Plan:
- 100 / 7: start at E0, data_in=100 in S_LDA, 7 in S_LDB -> quotient=14, remainder=2, done after E18, div_by_zero=0.
- 5 / 7 -> quotient=0, remainder=5, done after E4. Also 0 / 3 -> quotient=0, remainder=0, done after E4.
- 9 / 0 -> div_by_zero=1, quotient=16'hFFFF, remainder=9, done after E3. Then 12/4 back-to-back from S_DONE -> div_by_zero=0, quotient=3, remainder=0.
- 65535 / 65535 -> quotient=1, remainder=0. Also 65535 / 1 -> quotient=65535, remainder=0, done after E65539.
- 1000 / 3 with start pulsed again while busy -> result unaffected: quotient=333, remainder=1.
- Same operation with rst_n=0 asserted mid-S_SUB -> all outputs 0 immediately, state S_IDLE. After release, 20/6 -> quotient=3, remainder=2.

Source files
------------

// File: rtl/div_repeated_sub_pkg.sv
`default_nettype none
// ============================================================================
// div_repeated_sub_pkg : shared state encoding and default width for the
//                        repeated-subtraction divider.
// Revision : 1.0
// ============================================================================
package div_repeated_sub_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LDA  = 3'd1;
  localparam logic [2:0] S_LDB  = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_SUB  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_LDA  = S_LDA,
    ST_LDB  = S_LDB,
    ST_CHK  = S_CHK,
    ST_SUB  = S_SUB,
    ST_DONE = S_DONE
  } state_t;

endpackage : div_repeated_sub_pkg
`default_nettype wire

// File: rtl/div_datapath.sv
`default_nettype none
// ============================================================================
// div_datapath : remainder/divisor/quotient registers with guarded subtract,
//                quotient increment, >= compare and divisor zero detect.
// Revision : 1.0
// ============================================================================
module div_datapath
  import div_repeated_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ldR,
  input  logic             ldD,
  input  logic             clrQ,
  input  logic             sub_en,
  input  logic             set_dbz,
  input  logic [WIDTH-1:0] data_in,
  output logic             ge,
  output logic             dz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_inc;
  logic             w_ge;
  logic             w_step;

  assign w_ge   = (r_rem >= r_div);
  assign w_diff = r_rem - r_div;
  assign w_inc  = r_quo + {{(WIDTH-1){1'b0}}, 1'b1};
  // The compare guards the subtract, so the remainder can never wrap.
  assign w_step = sub_en & w_ge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_div <= '0;
      r_quo <= '0;
    end else begin
      if (ldR)
        r_rem <= data_in;
      else if (w_step)
        r_rem <= w_diff;

      if (ldD)
        r_div <= data_in;

      if (clrQ)
        r_quo <= '0;
      else if (set_dbz)
        r_quo <= '1;
      else if (w_step)
        r_quo <= w_inc;
    end
  end

  assign ge        = w_ge;
  assign dz        = (r_div == '0);
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule : div_datapath
`default_nettype wire

// File: rtl/div_repeated_sub.sv
`default_nettype none
// ============================================================================
// div_repeated_sub : sequential unsigned divider by repeated subtraction;
//                    controller FSM driving div_datapath.
// Revision : 1.0
// ============================================================================
module div_repeated_sub
  import div_repeated_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  state_t r_state;
  state_t w_next;
  logic   r_dbz;

  logic w_ldR;
  logic w_ldD;
  logic w_clrQ;
  logic w_sub_en;
  logic w_set_dbz;
  logic w_ge;
  logic w_dz;

  div_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .ldR       (w_ldR),
    .ldD       (w_ldD),
    .clrQ      (w_clrQ),
    .sub_en    (w_sub_en),
    .set_dbz   (w_set_dbz),
    .data_in   (data_in),
    .ge        (w_ge),
    .dz        (w_dz),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_ldR     = 1'b0;
    w_ldD     = 1'b0;
    w_clrQ    = 1'b0;
    w_sub_en  = 1'b0;
    w_set_dbz = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start)
          w_next = ST_LDA;
      end
      ST_LDA: begin
        w_ldR  = 1'b1;
        w_next = ST_LDB;
      end
      ST_LDB: begin
        w_ldD  = 1'b1;
        w_clrQ = 1'b1;
        w_next = ST_CHK;
      end
      ST_CHK: begin
        if (w_dz) begin
          w_set_dbz = 1'b1;
          w_next    = ST_DONE;
        end else begin
          w_next = ST_SUB;
        end
      end
      ST_SUB: begin
        if (w_ge)
          w_sub_en = 1'b1;
        else
          w_next = ST_DONE;
      end
      ST_DONE: begin
        if (start)
          w_next = ST_LDA;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Flag lives beside the FSM so that a restart from S_DONE drops it on E0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_dbz <= 1'b0;
    else if ((r_state == ST_CHK) && w_dz)
      r_dbz <= 1'b1;
    else if ((r_state == ST_DONE) && start)
      r_dbz <= 1'b0;
  end

  assign done        = (r_state == ST_DONE);
  assign busy        = (r_state == ST_LDA) || (r_state == ST_LDB) ||
                       (r_state == ST_CHK) || (r_state == ST_SUB);
  assign div_by_zero = r_dbz;

endmodule : div_repeated_sub
`default_nettype wire
